fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Instruction fetch stage sitting directly downstream of the program counter register, and feeding back into it.
- Consumes the current PC and issues a request/acknowledge read to instruction memory.
- Buffers fetched {pc, instruction} pairs in a small FIFO for decode.
- Drives the PC's write strobe and next-PC value (PC+4 or branch target).

Parameters:
DEPTH, 4, fetch queue entries (power of two, >=2)
CW, 3, count width; must equal clog2(DEPTH+1)

Ports:
CLOCK  in  1  sole clock, rising edge
RESET  in  1  synchronous, active-high reset
pc_in  in  64  current program counter value
pc_write  out  1  PC load strobe, one-cycle pulse
pc_next  out  64  value PC loads when pc_write=1
imem_req  out  1  instruction memory read request
imem_addr  out  64  read address, word aligned
imem_ack  in  1  memory data valid, one-cycle pulse
imem_rdata  in  32  instruction word, valid with imem_ack
branch_taken  in  1  redirect pulse from execute
branch_target  in  64  redirect PC, valid with branch_taken
if_valid  out  1  queue head valid (count!=0)
if_ready  in  1  decode accepts head
if_instr  out  32  head instruction
if_pc  out  64  head PC
count  out  CW  queue occupancy
fetch_fault  out  1  misalignment fault (see Optional Feature)

Behaviour:
- One clock (CLOCK); reset is synchronous and active-high (RESET).
- RESET=1 at an edge sets: state IDLE, count=0, imem_req=0, imem_addr=0, pc_write=0, pc_next=0, fetch_fault=0. It overrides all other inputs.
- States are IDLE, REQ, ADV and DROP. All outputs are registered except if_valid/if_instr/if_pc, which decode the queue head.
- IDLE:
  - If count<DEPTH and no branch_taken, register imem_req=1 and imem_addr={pc_in[63:2],2'b00}, then go to REQ.
  - If count==DEPTH, stay in IDLE with imem_req=0.
- REQ:
  - imem_req and imem_addr are held stable until imem_ack.
  - On imem_ack: push {imem_addr, imem_rdata}, drop imem_req, set pc_write=1 and pc_next=imem_addr+4 (wraps mod 2^64), then go to ADV.
- ADV: pc_write is high for exactly this cycle, so the PC updates at the end of ADV. Go to IDLE next, where the new pc_in is seen.
- Timing:
  - Minimum fetch loop is 3 cycles per instruction with a 1-cycle memory (IDLE, REQ, ADV).
  - Ack latency is unbounded.
- imem_ack outside REQ/DROP is ignored. This covers stale acks after reset.
- Redirect (branch_taken=1), highest priority over normal advance:
  - Queue is cleared (count=0) at that edge; any same-cycle pop is void.
  - Next cycle: pc_write=1, pc_next=branch_target.
  - Transitions: IDLE→ADV; ADV→ADV (redirect value wins); REQ without ack→DROP; REQ with same-cycle ack→ADV with the data discarded and no push.
  - fetch_fault clears.
- DROP:
  - imem_req stays high until imem_ack; the returned data is discarded; then go to IDLE.
  - A further branch_taken in DROP re-pulses pc_write with the new target and stays in DROP.
- Queue:
  - Pop when if_valid && if_ready.
  - Simultaneous push and pop leaves count unchanged and keeps FIFO order.
  - A pop at count==0 has no effect.
  - No push is possible at count==DEPTH, because no request is issued when full.
- Reset mid-request abandons the transaction: imem_req drops the following cycle. The memory must tolerate this.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined:
  - In IDLE, pc_in[1:0]!=0 suppresses the request and sets fetch_fault=1 (sticky).
  - The FSM stays in IDLE, issuing nothing, until branch_taken or RESET.
  - The queue still drains to decode.
- Undefined:
  - pc_in[1:0] is ignored; the address is force-aligned.
  - fetch_fault is tied 0.

Test Plan:
- Reset, pc_in=0, imem_ack 1 cycle after each req, if_ready=1 → addresses 0,4,8 issued; pc_write pulses with pc_next=4,8,12; if_pc/if_instr match in order.
- if_ready=0, DEPTH=4 → after 4 pushes count=4, imem_req stays 0; raise if_ready → count drops to 3, new request issued next IDLE.
- branch_taken with target 0x100 while REQ waits 5 cycles for ack → DROP, pc_write=1 with pc_next=0x100, late ack data not pushed, count=0, next fetch address 0x100.
- branch_taken coincident with imem_ack in REQ → no push, pc_next=target rather than addr+4.
- RESET asserted while imem_req=1 → next cycle imem_req=0, count=0, pc_write=0; a stale ack causes no push.
- With FETCH_MISALIGN_CHECK_EN, pc_in=0x6 → fetch_fault=1, no imem_req; branch_taken to 0x40 clears the fault and fetching resumes at 0x40. Without the macro → imem_addr=0x4, fetch_fault=0.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: drives the PC, issues req/ack instruction reads and
// queues {pc, instr} pairs for decode. Optional FETCH_MISALIGN_CHECK_EN adds a sticky fault.
module fetch_queue_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic [63:0]   pc_in,
    output logic          pc_write,
    output logic [63:0]   pc_next,
    output logic          imem_req,
    output logic [63:0]   imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    input  logic          branch_taken,
    input  logic [63:0]   branch_target,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [31:0]   if_instr,
    output logic [63:0]   if_pc,
    output logic [CW-1:0] count,
    output logic          fetch_fault
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, ADV, DROP} state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    state_t      state_q, state_d;
    logic        req_d, pc_write_d, push, pop, set_fault, misalign;
    logic [63:0] addr_d, pc_next_d;
    fq_entry_t   mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

`ifdef FETCH_MISALIGN_CHECK_EN
    // A sticky fault keeps the FSM parked in IDLE until a redirect.
    assign misalign = (pc_in[1:0] != 2'b00) || fetch_fault;

    always_ff @(posedge CLOCK) begin
        if (RESET)             fetch_fault <= 1'b0;
        else if (branch_taken) fetch_fault <= 1'b0;
        else if (set_fault)    fetch_fault <= 1'b1;
    end
`else
    logic unused_cfg;
    assign misalign    = 1'b0;
    assign fetch_fault = 1'b0;
    assign unused_cfg  = ^{pc_in[1:0], set_fault};
`endif

    // Next-state and registered-output decode; redirects take priority.
    always_comb begin
        state_d    = state_q;
        req_d      = imem_req;
        addr_d     = imem_addr;
        pc_write_d = 1'b0;
        pc_next_d  = pc_next;
        push       = 1'b0;
        set_fault  = 1'b0;
        case (state_q)
            IDLE: begin
                if (branch_taken) begin
                    pc_write_d = 1'b1;
                    pc_next_d  = branch_target;
                    state_d    = ADV;
                end else if (misalign) begin
                    set_fault = 1'b1;
                end else if (count < FULL) begin
                    req_d   = 1'b1;
                    addr_d  = {pc_in[63:2], 2'b00};
                    state_d = REQ;
                end
            end
            REQ: begin
                if (branch_taken) begin
                    pc_write_d = 1'b1;
                    pc_next_d  = branch_target;
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = ADV;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    push       = 1'b1;
                    req_d      = 1'b0;
                    pc_write_d = 1'b1;
                    pc_next_d  = imem_addr + 64'd4;
                    state_d    = ADV;
                end
            end
            ADV: begin
                if (branch_taken) begin
                    pc_write_d = 1'b1;
                    pc_next_d  = branch_target;
                end else begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (branch_taken) begin
                    pc_write_d = 1'b1;
                    pc_next_d  = branch_target;
                end
                // A redirect landing with the ack still needs its ADV cycle.
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = branch_taken ? ADV : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= 64'd0;
            pc_write  <= 1'b0;
            pc_next   <= 64'd0;
        end else begin
            state_q   <= state_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
            pc_write  <= pc_write_d;
            pc_next   <= pc_next_d;
        end
    end

    // Fetch queue; a redirect flushes it and voids any same-cycle pop.
    assign if_valid = (count != '0);
    assign if_instr = mem[rd_ptr].instr;
    assign if_pc    = mem[rd_ptr].pc;
    assign pop      = if_valid && if_ready && !branch_taken;

    always_ff @(posedge CLOCK) begin
        if (RESET || branch_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push && !RESET) mem[wr_ptr] <= '{pc: imem_addr, instr: imem_rdata};
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: models the PC register and instruction memory.
module tb_fetch_queue_unit;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [63:0] pc_in = 64'd0;
    logic        pc_write;
    logic [63:0] pc_next;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic [2:0]  count;
    logic        fetch_fault;

    int   tests = 0;
    int   fails = 0;
    ent_t exp_q[$];
    logic pend = 1'b0;
    ent_t pend_e;

    fetch_queue_unit #(.DEPTH(4), .CW(3)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .pc_in(pc_in), .pc_write(pc_write),
        .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
        .branch_target(branch_target), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .count(count), .fetch_fault(fetch_fault)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0013;
    endfunction

    // One clock: check/pop the consumed head, advance, update PC and scoreboard.
    task automatic step();
        logic pw, br, rst, pop;
        logic [63:0] pn;
        ent_t e;
        pw  = pc_write;
        pn  = pc_next;
        br  = branch_taken;
        rst = RESET;
        pop = if_valid && if_ready && !br && !rst;
        if (pop) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_empty: decode popped pc=%h but no entry expected", if_pc);
            end else begin
                e = exp_q.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr) begin
                    fails++;
                    $display("FAIL head: got pc=%h instr=%h expected pc=%h instr=%h",
                             if_pc, if_instr, e.pc, e.instr);
                end
            end
        end
        @(posedge CLOCK);
        #1;
        if (rst || br) exp_q.delete();
        else if (pend) exp_q.push_back(pend_e);
        pend = 1'b0;
        if (pw) pc_in = pn;
        tests++;
        if (count !== 3'(exp_q.size())) begin
            fails++;
            $display("FAIL count: got %0d expected %0d", count, exp_q.size());
        end
        tests++;
        if (if_valid !== (exp_q.size() != 0)) begin
            fails++;
            $display("FAIL if_valid: got %b expected %b", if_valid, exp_q.size() != 0);
        end
    endtask

    task automatic do_reset(input logic [63:0] start_pc);
        RESET = 1'b1;
        imem_ack = 1'b0;
        branch_taken = 1'b0;
        pend = 1'b0;
        step();
        step();
        RESET = 1'b0;
        pc_in = start_pc;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (imem_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (imem_req !== 1'b1) begin
            fails++;
            $display("FAIL req_timeout: imem_req=%b after %0d cycles, expected 1", imem_req, n);
        end
    endtask

    // Serve one request after lat idle cycles and check the PC update it causes.
    task automatic do_fetch(input int lat, input logic [63:0] exp_addr);
        wait_req(20);
        tests++;
        if (imem_addr !== exp_addr) begin
            fails++;
            $display("FAIL imem_addr: got %h expected %h", imem_addr, exp_addr);
        end
        for (int i = 0; i < lat; i++) step();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            fails++;
            $display("FAIL req_hold: got req=%b addr=%h expected req=1 addr=%h",
                     imem_req, imem_addr, exp_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = instr_of(imem_addr);
        pend       = 1'b1;
        pend_e     = '{pc: exp_addr, instr: instr_of(exp_addr)};
        step();
        imem_ack = 1'b0;
        tests++;
        if (pc_write !== 1'b1 || pc_next !== exp_addr + 64'd4 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL advance: got pc_write=%b pc_next=%h req=%b expected 1 %h 0",
                     pc_write, pc_next, imem_req, exp_addr + 64'd4);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        tests++;
        if (imem_req !== 1'b0 || imem_addr !== 64'd0 || pc_write !== 1'b0 ||
            pc_next !== 64'd0 || count !== 3'd0 || fetch_fault !== 1'b0) begin
            fails++;
            $display("FAIL reset: got req=%b addr=%h pw=%b pn=%h cnt=%0d flt=%b expected all 0",
                     imem_req, imem_addr, pc_write, pc_next, count, fetch_fault);
        end
    endtask

    task automatic test_basic();
        do_reset(64'd0);
        if_ready = 1'b1;
        do_fetch(0, 64'h0);
        do_fetch(1, 64'h4);
        do_fetch(2, 64'h8);
        step();
    endtask

    task automatic test_full();
        do_reset(64'h200);
        if_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_fetch(i % 2, 64'h200 + 64'(4 * i));
        tests++;
        if (count !== 3'd4) begin
            fails++;
            $display("FAIL full_count: got %0d expected 4", count);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (imem_req !== 1'b0) begin
                fails++;
                $display("FAIL full_req: got imem_req=%b expected 0", imem_req);
            end
        end
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        tests++;
        if (count !== 3'd3 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL drain_one: got count=%0d req=%b expected 3 0", count, imem_req);
        end
        step();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h210) begin
            fails++;
            $display("FAIL refill: got req=%b addr=%h expected 1 0000000000000210",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_push_pop();
        do_reset(64'h600);
        if_ready = 1'b0;
        do_fetch(0, 64'h600);
        do_fetch(0, 64'h604);
        wait_req(20);
        if_ready = 1'b1;
        do_fetch(0, 64'h608);
        tests++;
        if (count !== 3'd2) begin
            fails++;
            $display("FAIL push_pop: got count=%0d expected 2", count);
        end
        step();
        step();
    endtask

    task automatic test_branch_drop();
        do_reset(64'h300);
        if_ready = 1'b0;
        do_fetch(0, 64'h300);
        wait_req(20);
        step();
        step();
        branch_taken  = 1'b1;
        branch_target = 64'h100;
        step();
        branch_taken = 1'b0;
        tests++;
        if (pc_write !== 1'b1 || pc_next !== 64'h100 || imem_req !== 1'b1 || count !== 3'd0) begin
            fails++;
            $display("FAIL drop_redirect: got pw=%b pn=%h req=%b cnt=%0d expected 1 100 1 0",
                     pc_write, pc_next, imem_req, count);
        end
        step();
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        tests++;
        if (imem_req !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL drop_ack: got req=%b count=%0d expected 0 0", imem_req, count);
        end
        if_ready = 1'b1;
        do_fetch(0, 64'h100);
        step();
    endtask

    task automatic test_branch_ack();
        do_reset(64'h400);
        if_ready = 1'b0;
        wait_req(20);
        imem_ack      = 1'b1;
        imem_rdata    = instr_of(imem_addr);
        branch_taken  = 1'b1;
        branch_target = 64'h80;
        step();
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        tests++;
        if (pc_write !== 1'b1 || pc_next !== 64'h80 || imem_req !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL branch_ack: got pw=%b pn=%h req=%b cnt=%0d expected 1 80 0 0",
                     pc_write, pc_next, imem_req, count);
        end
        do_fetch(1, 64'h80);
    endtask

    task automatic test_reset_mid();
        do_reset(64'h500);
        if_ready = 1'b0;
        do_fetch(0, 64'h500);
        wait_req(20);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        tests++;
        if (imem_req !== 1'b0 || pc_write !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid: got req=%b pw=%b cnt=%0d expected 0 0 0",
                     imem_req, pc_write, count);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        step();
        imem_ack = 1'b0;
        tests++;
        if (count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 64'h504) begin
            fails++;
            $display("FAIL stale_ack: got cnt=%0d req=%b addr=%h expected 0 1 504",
                     count, imem_req, imem_addr);
        end
    endtask

    task automatic test_misalign();
        do_reset(64'h6);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
                fails++;
                $display("FAIL misalign: got fault=%b req=%b expected 1 0", fetch_fault, imem_req);
            end
        end
        branch_taken  = 1'b1;
        branch_target = 64'h40;
        step();
        branch_taken = 1'b0;
        tests++;
        if (fetch_fault !== 1'b0 || pc_write !== 1'b1 || pc_next !== 64'h40) begin
            fails++;
            $display("FAIL fault_clear: got fault=%b pw=%b pn=%h expected 0 1 40",
                     fetch_fault, pc_write, pc_next);
        end
        do_fetch(0, 64'h40);
`else
        wait_req(20);
        tests++;
        if (imem_addr !== 64'h4 || fetch_fault !== 1'b0) begin
            fails++;
            $display("FAIL force_align: got addr=%h fault=%b expected 4 0", imem_addr, fetch_fault);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_push_pop();
        test_branch_drop();
        test_branch_ack();
        test_reset_mid();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
